fpdiv_ctrl: RTL and testbench

Control sequencer for the `fpdiv` Goldschmidt divider datapath. It accepts a start request and steps the single shared multiplier through these phases:
- initial approximation;
- `NITER` N/D refinement iterations;
- a back-multiply for the remainder;
- a rounding decision.

It drives every mux select and register enable of the datapath, and returns a done pulse with the rounding select. It sits directly upstream of `fpdiv`. Operands `d` and `x` are held stable by the requester for the whole operation.

---
 rtl/fpdiv_ctrl_if.sv | 26 ++
 rtl/fpdiv_ctrl.sv | 156 +++++++++++++++
 tb/tb_fpdiv_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpdiv_ctrl_if.sv
// Handshake and datapath-control bundle between a division requester/datapath and fpdiv_ctrl.
// master = requester/datapath side, slave = the sequencer.
interface fpdiv_ctrl_if;
   logic       start;
   logic       rem_sign;
   logic       rem_zero;
   logic [1:0] sel_muxa;
   logic [1:0] sel_muxb;
   logic [1:0] sel_muxr;
   logic       enA;
   logic       enB;
   logic       enC;
   logic       enR;
   logic       busy;
   logic       done;

   modport master (
      output start, rem_sign, rem_zero,
      input  sel_muxa, sel_muxb, sel_muxr, enA, enB, enC, enR, busy, done
   );

   modport slave (
      input  start, rem_sign, rem_zero,
      output sel_muxa, sel_muxb, sel_muxr, enA, enB, enC, enR, busy, done
   );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divider sequencer: steps the shared multiplier through init, NITER
// refinement iterations, remainder back-multiply and rounding for the fpdiv datapath.
//
// state  | meaning
// IDLE   | waiting for start
// INIT_N | N1 = ia * x            -> regC
// INIT_D | D1 = ia * d -> regB, K1 = ~D1 -> regA; clear iter
// ITER_N | N <- K * N             -> regC
// ITER_D | D <- K * D -> regB, K <- ~D -> regA; iter++
// REM    | regR <- d * q
// ROUND  | capture rounding select from remainder sign/zero
// DONE   | done pulse, sel_muxr valid
module fpdiv_ctrl #(
   parameter int unsigned NITER = 3
) (
   input  logic         clock,
   input  logic         reset,
   fpdiv_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT_N = 3'd1,
      INIT_D = 3'd2,
      ITER_N = 3'd3,
      ITER_D = 3'd4,
      REM    = 3'd5,
      ROUND  = 3'd6,
      DONE   = 3'd7
   } state_t;

   localparam logic [3:0] ITER_LAST = 4'(NITER - 1);

   localparam logic [1:0] MUXA_REGA = 2'b00;
   localparam logic [1:0] MUXA_D    = 2'b01;
   localparam logic [1:0] MUXA_IA   = 2'b10;
   localparam logic [1:0] MUXB_D    = 2'b00;
   localparam logic [1:0] MUXB_X    = 2'b01;
   localparam logic [1:0] MUXB_REGB = 2'b10;
   localparam logic [1:0] MUXB_REGC = 2'b11;
   localparam logic [1:0] MUXR_Q    = 2'b00;
   localparam logic [1:0] MUXR_QP1  = 2'b01;
   localparam logic [1:0] MUXR_QM1  = 2'b10;

   state_t     state_q, state_d;
   logic [3:0] iter_q, iter_d;
   logic [1:0] sel_muxr_q, sel_muxr_d;

   logic [1:0] sel_muxa;
   logic [1:0] sel_muxb;
   logic       en_a;
   logic       en_b;
   logic       en_c;
   logic       en_r;
   logic       busy;
   logic       done;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         iter_q     <= 4'd0;
         sel_muxr_q <= MUXR_Q;
      end else begin
         state_q    <= state_d;
         iter_q     <= iter_d;
         sel_muxr_q <= sel_muxr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      iter_d     = iter_q;
      sel_muxr_d = sel_muxr_q;
      sel_muxa   = MUXA_REGA;
      sel_muxb   = MUXB_D;
      en_a       = 1'b0;
      en_b       = 1'b0;
      en_c       = 1'b0;
      en_r       = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (bus.start) begin
               state_d = INIT_N;
            end
         end
         INIT_N: begin
            sel_muxa = MUXA_IA;
            sel_muxb = MUXB_X;
            en_c     = 1'b1;
            state_d  = INIT_D;
         end
         INIT_D: begin
            sel_muxa = MUXA_IA;
            sel_muxb = MUXB_D;
            en_a     = 1'b1;
            en_b     = 1'b1;
            iter_d   = 4'd0;
            state_d  = ITER_N;
         end
         // N is refreshed first so regA (K) feeds both products before ITER_D overwrites it.
         ITER_N: begin
            sel_muxa = MUXA_REGA;
            sel_muxb = MUXB_REGC;
            en_c     = 1'b1;
            state_d  = ITER_D;
         end
         ITER_D: begin
            sel_muxa = MUXA_REGA;
            sel_muxb = MUXB_REGB;
            en_a     = 1'b1;
            en_b     = 1'b1;
            iter_d   = iter_q + 4'd1;
            state_d  = (iter_q == ITER_LAST) ? REM : ITER_N;
         end
         REM: begin
            sel_muxa = MUXA_D;
            sel_muxb = MUXB_REGC;
            en_r     = 1'b1;
            state_d  = ROUND;
         end
         // Exact remainder wins; otherwise a negative remainder means q overshot.
         ROUND: begin
            if (bus.rem_zero) begin
               sel_muxr_d = MUXR_Q;
            end else if (bus.rem_sign) begin
               sel_muxr_d = MUXR_QM1;
            end else begin
               sel_muxr_d = MUXR_QP1;
            end
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.sel_muxa = sel_muxa;
   assign bus.sel_muxb = sel_muxb;
   assign bus.sel_muxr = sel_muxr_q;
   assign bus.enA      = en_a;
   assign bus.enB      = en_b;
   assign bus.enC      = en_c;
   assign bus.enR      = en_r;
   assign bus.busy     = busy;
   assign bus.done     = done;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Self-checking bench for fpdiv_ctrl: per-cycle control traces, rounding, back-to-back,
// mid-op reset, NITER=1, and an end-to-end run against a behavioural Goldschmidt datapath.
module tb_fpdiv_ctrl;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   fpdiv_ctrl_if bus3 ();
   fpdiv_ctrl_if bus1 ();

   fpdiv_ctrl #(.NITER(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));
   fpdiv_ctrl #(.NITER(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

   logic start3, start1, rs_drv, rz_drv, e2e;

   // Behavioural datapath: unsigned fixed point, 27 fraction bits (1.0 = 0x8000000).
   logic [31:0] d_op, x_op, m_ia, mux_a, mux_b, m_prod, m_rem, m_q;
   logic [31:0] m_a, m_b, m_c, m_r;
   logic [63:0] prod_full;

   always_comb begin
      m_ia = 32'((64'd1 << 54) / {32'd0, d_op});
      case (bus3.sel_muxa)
         2'b00:   mux_a = m_a;
         2'b01:   mux_a = d_op;
         default: mux_a = m_ia;
      endcase
      case (bus3.sel_muxb)
         2'b00:   mux_b = d_op;
         2'b01:   mux_b = x_op;
         2'b10:   mux_b = m_b;
         default: mux_b = m_c;
      endcase
      prod_full = {32'd0, mux_a} * {32'd0, mux_b};
      m_prod    = prod_full[58:27];
      m_rem     = x_op - m_r;
      case (bus3.sel_muxr)
         2'b01:   m_q = m_c + 32'd1;
         2'b10:   m_q = m_c - 32'd1;
         default: m_q = m_c;
      endcase
   end

   always @(posedge clock) begin
      if (bus3.enA === 1'b1) m_a <= 32'h1000_0000 - m_prod;
      if (bus3.enB === 1'b1) m_b <= m_prod;
      if (bus3.enC === 1'b1) m_c <= m_prod;
      if (bus3.enR === 1'b1) m_r <= m_prod;
   end

   assign bus3.start    = start3;
   assign bus3.rem_sign = e2e ? m_rem[31] : rs_drv;
   assign bus3.rem_zero = e2e ? (m_rem == 32'd0) : rz_drv;
   assign bus1.start    = start1;
   assign bus1.rem_sign = rs_drv;
   assign bus1.rem_zero = rz_drv;

   logic [9:0] obs3, obs1;
   assign obs3 = {bus3.sel_muxa, bus3.sel_muxb, bus3.enA, bus3.enB, bus3.enC, bus3.enR, bus3.busy, bus3.done};
   assign obs1 = {bus1.sel_muxa, bus1.sel_muxb, bus1.enA, bus1.enB, bus1.enC, bus1.enR, bus1.busy, bus1.done};

   int vectors = 0;
   int miscompares = 0;
   logic [1:0] sb_q[$];

   // Expected {muxa, muxb, enA, enB, enC, enR, busy, done} in cycle k after the accepting edge.
   function automatic logic [9:0] exp_out(input int k, input int n);
      if (k == 1)                  return {2'b10, 2'b01, 4'b0010, 2'b10};
      if (k == 2)                  return {2'b10, 2'b00, 4'b1100, 2'b10};
      if (k >= 3 && k <= 2*n + 2)  return ((k % 2) == 1) ? {2'b00, 2'b11, 4'b0010, 2'b10}
                                                         : {2'b00, 2'b10, 4'b1100, 2'b10};
      if (k == 2*n + 3)            return {2'b01, 2'b11, 4'b0001, 2'b10};
      if (k == 2*n + 4)            return {2'b00, 2'b00, 4'b0000, 2'b10};
      if (k == 2*n + 5)            return {2'b00, 2'b00, 4'b0000, 2'b11};
      return 10'd0;
   endfunction

   // Scoreboard: every done pulse on the NITER=3 instance pops the expected rounding select.
   always @(negedge clock) begin
      if (bus3.done === 1'b1) begin
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected_done t=%0t sel_muxr=%b expected no done", $time, bus3.sel_muxr);
         end else begin
            logic [1:0] exp_sel;
            exp_sel = sb_q.pop_front();
            if (bus3.sel_muxr !== exp_sel) begin
               miscompares++;
               $display("FAIL sb_sel_muxr t=%0t got %b expected %b", $time, bus3.sel_muxr, exp_sel);
            end
         end
      end
   end

   task automatic pulse_start3();
      @(posedge clock); #1 start3 = 1'b1;
      @(posedge clock); #1 start3 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start3 = 1'b0; start1 = 1'b0;
      rs_drv = 1'b0; rz_drv = 1'b0; e2e = 1'b0;
      d_op = 32'h0400_0000; x_op = 32'h0600_0000;
      @(posedge clock); @(posedge clock); #1 reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         vectors++;
         if ({obs3, bus3.sel_muxr} !== 12'd0 || {obs1, bus1.sel_muxr} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_idle cycle %0d got %h/%h expected 000/000", k,
                     {obs3, bus3.sel_muxr}, {obs1, bus1.sel_muxr});
         end
      end
   endtask

   task automatic test_single();
      rs_drv = 1'b0; rz_drv = 1'b0;
      sb_q.push_back(2'b01);
      pulse_start3();
      for (int k = 1; k <= 14; k++) begin
         @(negedge clock);
         vectors++;
         if (obs3 !== exp_out(k, 3)) begin
            miscompares++;
            $display("FAIL single_trace cycle %0d got %b expected %b", k, obs3, exp_out(k, 3));
         end
      end
   endtask

   task automatic test_rounding();
      logic [1:0] cases_q[3] = '{2'b11, 2'b01, 2'b00};
      logic [1:0] exp_q[3]   = '{2'b00, 2'b10, 2'b01};
      for (int c = 0; c < 3; c++) begin
         {rz_drv, rs_drv} = cases_q[c];
         sb_q.push_back(exp_q[c]);
         pulse_start3();
         for (int k = 1; k <= 12; k++) @(negedge clock);
         {rz_drv, rs_drv} = ~cases_q[c];
         @(negedge clock); @(negedge clock);
         vectors++;
         if (bus3.sel_muxr !== exp_q[c]) begin
            miscompares++;
            $display("FAIL round_hold case %0d got %b expected %b", c, bus3.sel_muxr, exp_q[c]);
         end
      end
   endtask

   task automatic test_back_to_back();
      rs_drv = 1'b1; rz_drv = 1'b0;
      repeat (3) sb_q.push_back(2'b10);
      @(posedge clock); #1 start3 = 1'b1;
      @(posedge clock);
      for (int k = 1; k <= 40; k++) begin
         int kk;
         kk = (k < 36) ? (k % 12) : 0;
         @(negedge clock);
         vectors++;
         if (obs3 !== exp_out(kk, 3)) begin
            miscompares++;
            $display("FAIL b2b_trace cycle %0d got %b expected %b", k, obs3, exp_out(kk, 3));
         end
         if (k == 29) begin
            @(posedge clock); #1 start3 = 1'b0;
         end
      end
   endtask

   task automatic test_reset_midop();
      pulse_start3();
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         vectors++;
         if (obs3 !== exp_out(k, 3)) begin
            miscompares++;
            $display("FAIL midop_trace cycle %0d got %b expected %b", k, obs3, exp_out(k, 3));
         end
      end
      reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         vectors++;
         if ({obs3, bus3.sel_muxr} !== 12'd0) begin
            miscompares++;
            $display("FAIL midop_abort cycle %0d got %h expected 000", k, {obs3, bus3.sel_muxr});
         end
      end
      rs_drv = 1'b0; rz_drv = 1'b0;
      sb_q.push_back(2'b01);
      pulse_start3();
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         vectors++;
         if (obs3 !== exp_out(k, 3)) begin
            miscompares++;
            $display("FAIL midop_restart cycle %0d got %b expected %b", k, obs3, exp_out(k, 3));
         end
      end
   endtask

   task automatic test_niter1();
      rs_drv = 1'b1; rz_drv = 1'b0;
      @(posedge clock); #1 start1 = 1'b1;
      @(posedge clock); #1 start1 = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clock);
         vectors++;
         if (obs1 !== exp_out(k, 1)) begin
            miscompares++;
            $display("FAIL niter1_trace cycle %0d got %b expected %b", k, obs1, exp_out(k, 1));
         end
         if (k == 7) begin
            vectors++;
            if (bus1.sel_muxr !== 2'b10) begin
               miscompares++;
               $display("FAIL niter1_sel got %b expected 10", bus1.sel_muxr);
            end
         end
      end
   endtask

   task automatic test_e2e();
      bit seen;
      e2e = 1'b1;
      d_op = 32'h0400_0000;
      x_op = 32'h0600_0000;
      sb_q.push_back(2'b00);
      pulse_start3();
      seen = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clock);
         if (bus3.done === 1'b1) begin
            seen = 1'b1;
            vectors++;
            if (k != 11) begin
               miscompares++;
               $display("FAIL e2e_latency got %0d expected 11", k);
            end
            vectors++;
            if (m_q !== 32'h0C00_0000) begin
               miscompares++;
               $display("FAIL e2e_quotient got %h expected 0c000000", m_q);
            end
         end
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL e2e_timeout done not seen within 20 cycles expected 11");
      end
      @(negedge clock);
      e2e = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_rounding();
      test_back_to_back();
      test_reset_midop();
      test_niter1();
      test_e2e();
      repeat (3) @(negedge clock);
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover got %0d pending expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
